// File: rtl/keypad_emu.sv
// keypad_emu: emulates a 3x4 active-low keypad matrix for one key per command.
// Ports: clk, rstn (sync, active-low), cmd_valid/cmd_code/cmd_ready command
//   handshake, key_col column strobes in, key_row row lines out,
//   busy (press or gap), done (press/release finished), err (illegal code).
module keypad_emu #(
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_code,
    output logic       cmd_ready,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          pressed;
    logic [2:0]    col_q;
    logic [3:0]    row_q;

    logic [2:0] map_col;
    logic [3:0] map_row;
    logic       legal;
    logic       hit;

    always_comb begin
        map_col = 3'b111;
        map_row = 4'b1111;
        case (cmd_code)
            4'd1:    begin map_col = 3'b011; map_row = 4'b0111; end
            4'd2:    begin map_col = 3'b101; map_row = 4'b0111; end
            4'd3:    begin map_col = 3'b110; map_row = 4'b0111; end
            4'd4:    begin map_col = 3'b011; map_row = 4'b1011; end
            4'd5:    begin map_col = 3'b101; map_row = 4'b1011; end
            4'd6:    begin map_col = 3'b110; map_row = 4'b1011; end
            4'd7:    begin map_col = 3'b011; map_row = 4'b1101; end
            4'd8:    begin map_col = 3'b101; map_row = 4'b1101; end
            4'd9:    begin map_col = 3'b110; map_row = 4'b1101; end
            4'd10:   begin map_col = 3'b011; map_row = 4'b1110; end
            4'd0:    begin map_col = 3'b101; map_row = 4'b1110; end
            4'd11:   begin map_col = 3'b110; map_row = 4'b1110; end
            default: begin map_col = 3'b111; map_row = 4'b1111; end
        endcase
    end

    assign legal = (cmd_code <= 4'd11);

    assign cmd_ready = rstn && (state == IDLE);
    assign busy      = (state != IDLE);

    // Wired-AND matrix: any strobed column that carries the key pulls the row.
    assign hit     = pressed && (|(~key_col & ~col_q));
    assign key_row = hit ? row_q : 4'b1111;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
            col_q   <= 3'b111;
            row_q   <= 4'b1111;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (legal) begin
                            col_q   <= map_col;
                            row_q   <= map_row;
                            cnt     <= HOLD_LD;
                            pressed <= 1'b1;
                            state   <= PRESS;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (cnt == '0) begin
                        cnt     <= GAP_LD;
                        pressed <= 1'b0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emu.sv
// tb_keypad_emu: randomized + directed bench for keypad_emu with a
// cycle-level reference model and an event scoreboard for done/err pulses.
module tb_keypad_emu;

    localparam int H = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_code = 4'd0;
    logic [2:0] key_col = 3'b011;
    logic       cmd_ready;
    logic [3:0] key_row;
    logic       busy;
    logic       done;
    logic       err;

    keypad_emu #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk),
        .rstn(rstn),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_ready(cmd_ready),
        .key_col(key_col),
        .key_row(key_row),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int at;
    } ev_t;

    ev_t sb[$];

    // Model: press occupies cycles busy_from..press_end, busy until free_at-1.
    int busy_from = 0;
    int free_at   = 0;
    int press_end = -1;
    int m_code    = 0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(input int k);
        return (k >= busy_from) && (k < free_at);
    endfunction

    function automatic logic [3:0] exp_row(input int code, input logic [2:0] col);
        int r;
        int c;
        logic [3:0] rv;
        if (code == 0) begin
            r = 3; c = 1;
        end else if (code == 10) begin
            r = 3; c = 0;
        end else if (code == 11) begin
            r = 3; c = 2;
        end else begin
            r = (code - 1) / 3;
            c = (code - 1) % 3;
        end
        rv = ~(4'b1000 >> r);
        return (col[2-c] == 1'b0) ? rv : 4'b1111;
    endfunction

    function automatic logic [2:0] rcol();
        return 3'($urandom % 8);
    endfunction

    task automatic drive(input bit v, input int code, input logic [2:0] col,
                         input bit r, output bit acc);
        int k;
        @(negedge clk);
        cmd_valid = v;
        cmd_code  = 4'(code);
        key_col   = col;
        rstn      = r;
        k = cyc;
        acc = 1'b0;
        if (!r) begin
            if (free_at > k + 1) free_at = k + 1;
            if (press_end > k) press_end = k;
            while (sb.size() > 0 && sb[$].at > k) void'(sb.pop_back());
        end else if (v && !m_busy(k)) begin
            acc = 1'b1;
            if (code < 12) begin
                m_code    = code;
                busy_from = k + 1;
                press_end = k + H;
                free_at   = k + H + G + 1;
                sb.push_back('{is_err: 1'b0, at: k + H + G + 1});
            end else begin
                sb.push_back('{is_err: 1'b1, at: k + 1});
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        bit a;
        n = 0;
        while (m_busy(cyc + 1) && n < 100) begin
            drive(1'b0, 0, rcol(), 1'b1, a);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout cycle %0d: got busy expected idle", cyc);
        end
    endtask

    // Monitor: checks levels every cycle, pops scoreboard on done/err pulses.
    initial begin
        int k;
        ev_t e;
        logic [3:0] row_e;
        forever begin
            @(negedge clk);
            #2;
            k = cyc;
            if (k >= 1) begin
                row_e = (k >= busy_from && k <= press_end)
                        ? exp_row(m_code, key_col) : 4'b1111;
                check("key_row", 32'(key_row), 32'(row_e));
                check("busy", 32'(busy), 32'(m_busy(k)));
                check("cmd_ready", 32'(cmd_ready), 32'(rstn && !m_busy(k)));
                while (sb.size() > 0 && sb[0].at < k) begin
                    e = sb.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_pulse cycle %0d: got none expected %s at %0d",
                             k, e.is_err ? "err" : "done", e.at);
                end
                if (done || err) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pulse cycle %0d: got done=%b err=%b expected none",
                                 k, done, err);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_err", 32'(err), 32'(e.is_err));
                        check("pulse_done", 32'(done), 32'(!e.is_err));
                        check("pulse_cycle", 32'(k), 32'(e.at));
                    end
                end
            end
        end
    end

    initial begin
        bit a;
        int n;
        int cc[4];
        logic [2:0] cl[4];
        logic [2:0] scan[3];
        cc = '{10, 0, 11, 11};
        cl = '{3'b011, 3'b101, 3'b110, 3'b011};
        scan = '{3'b011, 3'b101, 3'b110};

        repeat (3) drive(1'b0, 0, 3'b011, 1'b0, a);

        wait_idle();
        drive(1'b1, 5, 3'b011, 1'b1, a);
        for (int i = 0; i < H + G + 3; i++) drive(1'b0, 0, scan[i % 3], 1'b1, a);

        for (int i = 0; i < 4; i++) begin
            wait_idle();
            drive(1'b1, cc[i], cl[i], 1'b1, a);
            repeat (H + G + 1) drive(1'b0, 0, cl[i], 1'b1, a);
        end

        wait_idle();
        drive(1'b1, 13, 3'b111, 1'b1, a);
        drive(1'b1, 1, 3'b011, 1'b1, a);
        repeat (H + G + 1) drive(1'b0, 0, 3'b011, 1'b1, a);

        wait_idle();
        drive(1'b1, 3, rcol(), 1'b1, a);
        a = 1'b0;
        n = 0;
        while (!a && n < 100) begin
            drive(1'b1, 7, rcol(), 1'b1, a);
            n++;
        end
        if (!a) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_timeout cycle %0d: got no accept expected accept", cyc);
        end
        repeat (H + G + 2) drive(1'b0, 0, rcol(), 1'b1, a);

        wait_idle();
        drive(1'b1, 5, 3'b101, 1'b1, a);
        drive(1'b0, 0, 3'b101, 1'b1, a);
        drive(1'b0, 0, 3'b101, 1'b0, a);
        drive(1'b1, 8, 3'b101, 1'b1, a);
        repeat (H + G + 2) drive(1'b0, 0, 3'b101, 1'b1, a);

        for (int i = 0; i < 600; i++) begin
            drive(bit'($urandom % 2), int'($urandom % 16), rcol(),
                  ($urandom % 60) != 0, a);
        end

        drive(1'b0, 0, 3'b111, 1'b1, a);
        wait_idle();
        repeat (3) drive(1'b0, 0, 3'b111, 1'b1, a);
        @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pending_events: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_emu.md
# keypad_emu

Behavioural keypad matrix emulator that sits at the opposite end of the 3-column × 4-row keypad scan interface. It takes the scanner's active-low column strobes and drives the active-low row lines as a physical 12-key pad would, for a key chosen through a command handshake. Each command is one press/release: the key is held for a fixed number of cycles, then released for a fixed gap. Used for on-board self-test and simulation of the keypad scan path without a real keypad.

## Interface
- HOLD_CYCLES, 64, cycles the key stays pressed per command; legal range ≥1
- GAP_CYCLES, 16, released cycles after each press before the next command is accepted; legal range ≥1
- clk  in  1  system clock, all flops rising-edge
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_code  in  4  key code: 0–9 = digits, 10 = '*', 11 = '#', 12–15 illegal
- cmd_ready  out  1  emulator can accept a command
- key_col  in  3  column strobes from the scanner, active-low; bit2 = column1, bit1 = column2, bit0 = column3
- key_row  out  4  row lines to the scanner, active-low; bit3 = row1 … bit0 = row4
- busy  out  1  press or gap in progress
- done  out  1  one-cycle pulse when a press/release completes
- err  out  1  one-cycle pulse when an illegal code is offered

## Operation
- Key map (column, row): 1 (c1, r1), 2 (c2, r1), 3 (c3, r1); 4/5/6 on r2; 7/8/9 on r3; '*' (c1, r4), 0 (c2, r4), '#' (c3, r4).
- Row encoding: r1 = 4'b0111, r2 = 4'b1011, r3 = 4'b1101, r4 = 4'b1110, none = 4'b1111.
- Internal registered state: FSM state, latched key column (3-bit, one-hot low), latched key row (4-bit, one-hot low), `pressed` flag, down-counter sized to max(HOLD_CYCLES, GAP_CYCLES).
- key_row is purely combinational from key_col and the registered press state, with no flop in the path. The scanner samples rows in the same cycle it drives a column.
  - key_row = latched row when pressed = 1 and key_col has a 0 in the latched key's column bit; otherwise 4'b1111.
  - Multiple low column bits act as a wired-AND matrix: the row is driven low if any low column bit matches. key_col = 3'b111 always yields 4'b1111.
- FSM states:
  - IDLE: cmd_ready = 1, pressed = 0.
    - On cmd_valid & cmd_ready with code ≤ 11: latch the column/row, load counter = HOLD_CYCLES−1, go to PRESS.
    - With code ≥ 12: pulse err, stay in IDLE, latch nothing.
  - PRESS: pressed = 1, busy = 1. Decrement each cycle. At counter = 0, load GAP_CYCLES−1 and go to GAP.
  - GAP: pressed = 0, busy = 1. Decrement each cycle. At counter = 0, go to IDLE and pulse done.
- cmd_code and cmd_valid are ignored outside IDLE, since cmd_ready = 0 there.
- Reset (rstn low at a clock edge) forces state IDLE, pressed 0, counter 0, latched row/column all-ones, done 0, err 0.
  - While rstn is low, cmd_ready is forced to 0.
  - A press in flight is abandoned with no done pulse. key_row returns to 4'b1111 right after the reset edge.

## Timing
- Reset values: key_row 4'b1111, cmd_ready 0 (while rstn low), busy 0, done 0, err 0.
- Command accepted at edge N. From N+1:
  - pressed = 1 and busy = 1 for exactly HOLD_CYCLES cycles;
  - then GAP_CYCLES cycles with pressed = 0 and busy = 1;
  - then done = 1 for one cycle, in the first IDLE cycle (N+1+HOLD_CYCLES+GAP_CYCLES). busy = 0 and cmd_ready = 1 in that same cycle.
- Back-to-back commands: a command offered during the done cycle is accepted. Minimum command period is 1+HOLD_CYCLES+GAP_CYCLES cycles.
- err is asserted in the cycle after the illegal offer (registered). cmd_ready stays 1, so a legal code can be accepted in the next cycle.
- key_row responds to a key_col change within the same cycle (zero latency).

## Test plan
- Reset: hold rstn = 0 for 3 cycles, key_col = 3'b011 → key_row = 4'b1111, cmd_ready = 0, busy = 0. Release reset → cmd_ready = 1.
- Press '5' (code 5), HOLD = 4, GAP = 2, key_col cycling 011→101→110:
  - key_row = 4'b1011 only while key_col = 3'b101, during exactly the 4 PRESS cycles;
  - done pulses at N+7;
  - scanner-in-loop variant: scanner key_data = 12'b1111_1011_1111.
- Corner keys: codes 10, 0, 11 with key_col fixed at 011, 101, 110 respectively → key_row = 4'b1110 in each case. Code 11 with key_col = 3'b011 → 4'b1111.
- Illegal code 13 offered in IDLE → err pulse 1 cycle, busy stays 0, key_row 4'b1111. Code 1 offered next cycle → accepted.
- Back-to-back: code 3 then code 7, with cmd_valid held high → second accept in the done cycle. Second press begins exactly 1+HOLD+GAP cycles after the first. cmd_valid held during busy is ignored.
- Reset mid-press: rstn = 0 for one cycle at PRESS cycle 2 → next cycle key_row = 4'b1111, busy 0, no done pulse. A new command is accepted after rstn returns to 1.
